// File: rtl/prog_loader_pkg.sv
// cpuConfig: picoMIPS field widths, opcode encodings and loader state encoding
package cpuConfig;
    localparam int O_SIZE = 3;
    localparam int R_SIZE = 3;
    localparam int D_SIZE = 8;
    localparam int P_SIZE = 5;
    localparam int I_SIZE = O_SIZE + 2 * R_SIZE + D_SIZE;
    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ADD  = 3'd1,
        ADDI = 3'd2,
        MUL  = 3'd3,
        MULI = 3'd4,
        LDS  = 3'd5
    } opCode_t;
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERR
    } loadState_t;
endpackage

// File: rtl/instr_encoder.sv
// instr_encoder: masks unused fields per opcode and packs {op, rd, rs, imm}
module instr_encoder #(
    parameter int O_SIZE = cpuConfig::O_SIZE,
    parameter int R_SIZE = cpuConfig::R_SIZE,
    parameter int D_SIZE = cpuConfig::D_SIZE
) (
    input  logic [O_SIZE-1:0]                  op,
    input  logic [R_SIZE-1:0]                  rd,
    input  logic [R_SIZE-1:0]                  rs,
    input  logic [D_SIZE-1:0]                  imm,
    output logic [O_SIZE+2*R_SIZE+D_SIZE-1:0]  word,
    output logic                               illegal
);
    import cpuConfig::*;
    logic keepRd, keepRs, keepImm;
    assign illegal = op > O_SIZE'(LDS);
    assign keepRd  = op != O_SIZE'(NOP) && !illegal;
    assign keepRs  = keepRd && op != O_SIZE'(LDS);
    assign keepImm = op == O_SIZE'(ADDI) || op == O_SIZE'(MULI);
    assign word    = illegal ? '0 : {op, {R_SIZE{keepRd}} & rd, {R_SIZE{keepRs}} & rs, {D_SIZE{keepImm}} & imm};
endmodule

// File: rtl/prog_loader.sv
// prog_loader: accepts host instruction bundles, encodes them and writes program memory while holding the CPU
module prog_loader #(
    parameter int O_SIZE = cpuConfig::O_SIZE,
    parameter int R_SIZE = cpuConfig::R_SIZE,
    parameter int D_SIZE = cpuConfig::D_SIZE,
    parameter int P_SIZE = cpuConfig::P_SIZE
) (
    input  logic                              clk,
    input  logic                              nReset,
    input  logic                              start,
    input  logic                              inValid,
    output logic                              inReady,
    input  logic [O_SIZE-1:0]                 inOpCode,
    input  logic [R_SIZE-1:0]                 inRd,
    input  logic [R_SIZE-1:0]                 inRs,
    input  logic [D_SIZE-1:0]                 inImm,
    input  logic                              inLast,
    output logic                              memWe,
    output logic [P_SIZE-1:0]                 memAddr,
    output logic [O_SIZE+2*R_SIZE+D_SIZE-1:0] memData,
    output logic                              cpuHold,
    output logic                              done,
    output logic                              error,
    output logic [P_SIZE:0]                   wordCount
);
    import cpuConfig::*;
    localparam int I_SIZE = O_SIZE + 2 * R_SIZE + D_SIZE;
    loadState_t state;
    logic lastQ;
    logic [I_SIZE-1:0] encWord;
    logic encIllegal;
    instr_encoder #(.O_SIZE(O_SIZE), .R_SIZE(R_SIZE), .D_SIZE(D_SIZE)) uEnc (
        .op(inOpCode),
        .rd(inRd),
        .rs(inRs),
        .imm(inImm),
        .word(encWord),
        .illegal(encIllegal)
    );
    // Session FSM: one accept then one write strobe per word; the last address ends the session so memAddr never wraps
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            inReady   <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memData   <= '0;
            cpuHold   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wordCount <= '0;
            lastQ     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LOAD;
                        inReady   <= 1'b1;
                        cpuHold   <= 1'b1;
                        memAddr   <= '0;
                        wordCount <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (inValid && inReady) begin
                        inReady <= 1'b0;
                        if (encIllegal) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state   <= WRITE;
                            memData <= encWord;
                            lastQ   <= inLast;
                            memWe   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    memWe     <= 1'b0;
                    wordCount <= wordCount + (P_SIZE+1)'(1);
                    if (lastQ || &memAddr) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        cpuHold <= 1'b0;
                    end else begin
                        state   <= LOAD;
                        memAddr <= memAddr + P_SIZE'(1);
                        inReady <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for the program loader
module tb_prog_loader;
    logic clk, nReset, start, inValid, inReady, inLast, memWe, cpuHold, done, error;
    logic [2:0] inOpCode, inRd, inRs;
    logic [7:0] inImm;
    logic [4:0] memAddr;
    logic [16:0] memData;
    logic [5:0] wordCount;
    int checks, errors, writes, base;

    prog_loader dut (
        .clk(clk), .nReset(nReset), .start(start), .inValid(inValid), .inReady(inReady),
        .inOpCode(inOpCode), .inRd(inRd), .inRs(inRs), .inImm(inImm), .inLast(inLast),
        .memWe(memWe), .memAddr(memAddr), .memData(memData), .cpuHold(cpuHold),
        .done(done), .error(error), .wordCount(wordCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count every write strobe seen by memory
    always @(posedge clk) if (memWe) writes++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitReady();
        for (int i = 0; i < 8 && !inReady; i++) @(negedge clk);
        chk("ready_timeout", {31'd0, inReady}, 1);
    endtask

    task automatic startPulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic setBundle(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                             input logic [7:0] imm, input logic last);
        inOpCode = op; inRd = rd; inRs = rs; inImm = imm; inLast = last; inValid = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [7:0] imm, input logic last,
                        input logic [4:0] expAddr, input logic [16:0] expData);
        setBundle(op, rd, rs, imm, last);
        waitReady();
        @(negedge clk);
        chk("write_we", {31'd0, memWe}, 1);
        chk("write_addr", {27'd0, memAddr}, {27'd0, expAddr});
        chk("write_data", {15'd0, memData}, {15'd0, expData});
        inValid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; writes = 0;
        nReset = 1'b0; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
        inOpCode = '0; inRd = '0; inRs = '0; inImm = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, inReady}, 0);
        chk("rst_we", {31'd0, memWe}, 0);
        chk("rst_hold", {31'd0, cpuHold}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        chk("rst_addr", {27'd0, memAddr}, 0);
        chk("rst_data", {15'd0, memData}, 0);
        chk("rst_count", {26'd0, wordCount}, 0);
        nReset = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, inReady}, 0);

        // session 1: ADDI, MUL, LDS(last)
        startPulse();
        chk("s1_hold", {31'd0, cpuHold}, 1);
        chk("s1_ready", {31'd0, inReady}, 1);
        send(3'd2, 3'd1, 3'd2, 8'h05, 1'b0, 5'd0, 17'b010_001_010_00000101);
        chk("s1_count1", {26'd0, wordCount}, 1);
        send(3'd3, 3'd3, 3'd1, 8'hFF, 1'b0, 5'd1, 17'b011_011_001_00000000);
        send(3'd5, 3'd4, 3'd7, 8'hAA, 1'b1, 5'd2, 17'b101_100_000_00000000);
        chk("s1_done", {31'd0, done}, 1);
        chk("s1_hold_end", {31'd0, cpuHold}, 0);
        chk("s1_count", {26'd0, wordCount}, 3);
        chk("s1_we_end", {31'd0, memWe}, 0);
        chk("s1_data_held", {15'd0, memData}, {15'd0, 17'b101_100_000_00000000});
        chk("s1_addr_held", {27'd0, memAddr}, 2);

        // session 2: NOP, ADD, MULI(last)
        startPulse();
        chk("s2_done_clr", {31'd0, done}, 0);
        chk("s2_count_clr", {26'd0, wordCount}, 0);
        send(3'd0, 3'd5, 3'd5, 8'hFF, 1'b0, 5'd0, 17'b000_000_000_00000000);
        send(3'd1, 3'd2, 3'd3, 8'h77, 1'b0, 5'd1, 17'b001_010_011_00000000);
        send(3'd4, 3'd7, 3'd6, 8'h81, 1'b1, 5'd2, 17'b100_111_110_10000001);
        chk("s2_done", {31'd0, done}, 1);

        // session 3: host holds inValid continuously
        startPulse();
        base = writes;
        for (int k = 0; k < 4; k++) begin
            setBundle(3'd2, 3'd1, 3'd2, 8'(k), k == 3);
            chk("cv_ready_hi", {31'd0, inReady}, 1);
            chk("cv_we_lo", {31'd0, memWe}, 0);
            @(negedge clk);
            chk("cv_we_hi", {31'd0, memWe}, 1);
            chk("cv_ready_lo", {31'd0, inReady}, 0);
            chk("cv_addr", {27'd0, memAddr}, k);
            chk("cv_data", {15'd0, memData}, {15'd0, 3'b010, 3'b001, 3'b010, 8'(k)});
            @(negedge clk);
        end
        inValid = 1'b0;
        chk("cv_done", {31'd0, done}, 1);
        chk("cv_count", {26'd0, wordCount}, 4);
        chk("cv_writes", writes - base, 4);

        // session 4: illegal opcode as second bundle
        startPulse();
        base = writes;
        send(3'd2, 3'd1, 3'd2, 8'h33, 1'b0, 5'd0, 17'b010_001_010_00110011);
        setBundle(3'd7, 3'd1, 3'd1, 8'h01, 1'b0);
        waitReady();
        @(negedge clk);
        inValid = 1'b0;
        chk("err_flag", {31'd0, error}, 1);
        chk("err_hold", {31'd0, cpuHold}, 1);
        chk("err_we", {31'd0, memWe}, 0);
        chk("err_ready", {31'd0, inReady}, 0);
        chk("err_count", {26'd0, wordCount}, 1);
        @(negedge clk);
        chk("err_sticky", {31'd0, error}, 1);
        chk("err_writes", writes - base, 1);
        startPulse();
        chk("err_clr", {31'd0, error}, 0);
        chk("err_clr_hold", {31'd0, cpuHold}, 1);
        chk("err_clr_ready", {31'd0, inReady}, 1);

        // start during LOAD is ignored
        send(3'd2, 3'd1, 3'd2, 8'h44, 1'b0, 5'd0, 17'b010_001_010_01000100);
        startPulse();
        chk("ign_addr", {27'd0, memAddr}, 1);
        chk("ign_count", {26'd0, wordCount}, 1);
        chk("ign_ready", {31'd0, inReady}, 1);
        send(3'd2, 3'd1, 3'd2, 8'h55, 1'b1, 5'd1, 17'b010_001_010_01010101);
        chk("ign_count_end", {26'd0, wordCount}, 2);

        // session 5: fill all 32 addresses without inLast
        startPulse();
        base = writes;
        for (int i = 0; i < 32; i++)
            send(3'd2, 3'd1, 3'd2, 8'(i), 1'b0, 5'(i), {3'b010, 3'b001, 3'b010, 8'(i)});
        chk("full_done", {31'd0, done}, 1);
        chk("full_count", {26'd0, wordCount}, 32);
        chk("full_addr", {27'd0, memAddr}, 31);
        chk("full_hold", {31'd0, cpuHold}, 0);
        setBundle(3'd2, 3'd1, 3'd2, 8'hEE, 1'b0);
        repeat (3) @(negedge clk);
        inValid = 1'b0;
        chk("full_no_wrap", writes - base, 32);
        chk("full_ready", {31'd0, inReady}, 0);

        // async reset while memWe is high
        startPulse();
        setBundle(3'd2, 3'd1, 3'd2, 8'h66, 1'b0);
        waitReady();
        @(negedge clk);
        chk("ar_we_pre", {31'd0, memWe}, 1);
        #2 nReset = 1'b0;
        #1;
        chk("ar_we", {31'd0, memWe}, 0);
        chk("ar_hold", {31'd0, cpuHold}, 0);
        chk("ar_count", {26'd0, wordCount}, 0);
        chk("ar_ready", {31'd0, inReady}, 0);
        chk("ar_addr", {27'd0, memAddr}, 0);
        chk("ar_data", {15'd0, memData}, 0);
        inValid = 1'b0;
        @(negedge clk);
        nReset = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_idle_ready", {31'd0, inReady}, 0);
        chk("ar_idle_hold", {31'd0, cpuHold}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
